// File: rtl/mvm_post_relu.sv
// Post-MVM stage: per-row bias add, arithmetic shift, ReLU and 14-bit saturation.
// Define MVM_POST_ROUND_EN to round half toward +inf before the shift (SHIFT>0 only).
module mvm_post_relu #(
   parameter int K      = 3,
   parameter int IN_W   = 28,
   parameter int OUT_W  = 14,
   parameter int BIAS_W = 14,
   parameter int SHIFT  = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     input_valid,
   output logic                     input_ready,
   input  logic signed [IN_W-1:0]   input_data,
   input  logic                     bias_wr_en,
   input  logic [$clog2(K)-1:0]     bias_wr_addr,
   input  logic signed [BIAS_W-1:0] bias_wr_data,
   output logic                     output_valid,
   input  logic                     output_ready,
   output logic [OUT_W-1:0]         output_data,
   output logic                     output_last
);

   localparam int AW = $clog2(K);
`ifdef MVM_POST_ROUND_EN
   localparam logic signed [IN_W+1:0] ROUND_C =
      (SHIFT > 0) ? ((IN_W+2)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
   localparam logic signed [IN_W+1:0] ROUND_C = '0;
`endif

   logic signed [BIAS_W-1:0] bias_q [K];
   logic [AW-1:0]            row_q, row_d;
   logic                     s1_v_q, s1_v_d, s1_last_q, s1_last_d;
   logic signed [IN_W:0]     s1_sum_q, s1_sum_d;
   logic                     s2_v_q, s2_v_d, s2_last_q, s2_last_d;
   logic [OUT_W-1:0]         s2_data_q, s2_data_d;
   logic                     s2_ready, accept;
   logic signed [IN_W+1:0]   rnd_sum, sh;

   always_comb begin
      s2_ready    = !s2_v_q || output_ready;
      input_ready = !s1_v_q || s2_ready;
      accept      = input_valid && input_ready;

      row_d = row_q;
      if (accept) row_d = (row_q == AW'(K-1)) ? '0 : row_q + 1'b1;

      s1_v_d    = s1_v_q;
      s1_sum_d  = s1_sum_q;
      s1_last_d = s1_last_q;
      if (input_ready) begin
         s1_v_d    = input_valid;
         s1_sum_d  = (IN_W+1)'(input_data) + (IN_W+1)'(bias_q[row_q]);
         s1_last_d = (row_q == AW'(K-1));
      end

      rnd_sum = (IN_W+2)'(s1_sum_q) + ROUND_C;
      sh      = rnd_sum >>> SHIFT;

      s2_v_d    = s2_v_q;
      s2_last_d = s2_last_q;
      s2_data_d = s2_data_q;
      if (s2_ready) begin
         s2_v_d    = s1_v_q;
         s2_last_d = s1_last_q;
         // sh is non-negative past the sign test, so any set bit at or above OUT_W-1 means overflow
         if (sh[IN_W+1])
            s2_data_d = '0;
         else if (|sh[IN_W+1:OUT_W-1])
            s2_data_d = {1'b0, {(OUT_W-1){1'b1}}};
         else
            s2_data_d = sh[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q     <= '0;
         s1_v_q    <= 1'b0;
         s1_sum_q  <= '0;
         s1_last_q <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_last_q <= 1'b0;
         for (int unsigned i = 0; i < K; i++) bias_q[i] <= '0;
      end else begin
         row_q     <= row_d;
         s1_v_q    <= s1_v_d;
         s1_sum_q  <= s1_sum_d;
         s1_last_q <= s1_last_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
         s2_last_q <= s2_last_d;
         if (bias_wr_en && (int'(bias_wr_addr) < K))
            bias_q[bias_wr_addr] <= bias_wr_data;
      end
   end

   assign output_valid = s2_v_q;
   assign output_data  = s2_data_q;
   assign output_last  = s2_last_q;

endmodule

// File: tb/tb_mvm_post_relu.sv
// Scoreboard bench for mvm_post_relu; a second instance covers SHIFT=2.
module tb_mvm_post_relu;

   typedef struct {
      logic [13:0] d;
      logic        l;
      int          due;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               input_valid, input_ready;
   logic signed [27:0] input_data;
   logic               bias_wr_en;
   logic [1:0]         bias_wr_addr;
   logic signed [13:0] bias_wr_data;
   logic               output_valid, output_ready, output_last;
   logic [13:0]        output_data;

   logic               b_iv, b_ir, b_ov, b_ol;
   logic signed [27:0] b_id;
   logic [13:0]        b_od;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   acc_cnt = 0;
   int   tb_row  = 0;
   exp_t exp_q[$];

   mvm_post_relu #(.K(3), .IN_W(28), .OUT_W(14), .BIAS_W(14), .SHIFT(0)) dut (
      .clk(clk), .reset(reset),
      .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
      .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
      .output_valid(output_valid), .output_ready(output_ready),
      .output_data(output_data), .output_last(output_last)
   );

   mvm_post_relu #(.K(3), .IN_W(28), .OUT_W(14), .BIAS_W(14), .SHIFT(2)) dut_sh2 (
      .clk(clk), .reset(reset),
      .input_valid(b_iv), .input_ready(b_ir), .input_data(b_id),
      .bias_wr_en(1'b0), .bias_wr_addr(2'd0), .bias_wr_data(14'sd0),
      .output_valid(b_ov), .output_ready(1'b1),
      .output_data(b_od), .output_last(b_ol)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!reset && input_valid && input_ready) acc_cnt = acc_cnt + 1;
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (output_valid && output_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0d, expected no output", output_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", int'(output_data), int'(e.d));
            check("out_last", int'(output_last), int'(e.l));
            if (e.due != 0) check("out_latency_cycle", cyc, e.due);
         end
      end
   end

   task automatic expect_out(input int d, input int due);
      exp_t e;
      e.d   = 14'(d);
      e.l   = (tb_row == 2);
      e.due = due;
      exp_q.push_back(e);
      tb_row = (tb_row == 2) ? 0 : tb_row + 1;
   endtask

   // Presents one element (optionally with a bias write on the accept edge);
   // returns the cycle in which it was presented and accepted.
   task automatic send(input int d, input logic we, input int wa, input int wd, output int pcyc);
      int n;
      n = 0;
      input_valid = 1'b1;
      input_data  = 28'(d);
      #1;
      while (!input_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!input_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got input_ready=0, expected 1 within 50 cycles");
      end
      bias_wr_en   = we;
      bias_wr_addr = 2'(wa);
      bias_wr_data = 14'(wd);
      pcyc = cyc;
      @(posedge clk); #1;
      bias_wr_en = 1'b0;
   endtask

   task automatic send_exp(input int d, input int ed);
      int p;
      send(d, 1'b0, 0, 0, p);
      expect_out(ed, p + 2);
   endtask

   task automatic write_bias(input int a, input int v);
      bias_wr_en   = 1'b1;
      bias_wr_addr = 2'(a);
      bias_wr_data = 14'(v);
      @(posedge clk); #1;
      bias_wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      input_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic sh2_case(input int d, input int req, input string name);
      int n;
      b_iv = 1'b1;
      b_id = 28'(d);
      @(posedge clk); #1;
      b_iv = 1'b0;
      n = 0;
      @(negedge clk);
      while (!b_ov && n < 10) begin @(negedge clk); n++; end
      check({name, "_valid"}, int'(b_ov), 1);
      check(name, int'(b_od), req);
   endtask

   initial begin
      int p, base, rel;
      reset = 1'b1;
      input_valid = 1'b0; input_data = '0;
      bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
      output_ready = 1'b1;
      b_iv = 1'b0; b_id = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(output_valid), 0);
      check("rst_data",  int'(output_data), 0);
      check("rst_last",  int'(output_last), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // passthrough with saturation and ReLU
      send_exp(100, 100);
      send_exp(-5, 0);
      send_exp(20000, 8191);
      idle(3);

      // biases
      write_bias(1, -50);
      write_bias(2, 7);
      send_exp(10, 10);
      send_exp(60, 10);
      send_exp(-7, 0);
      idle(2);
      send_exp(9, 9);
      send(60, 1'b1, 1, 0, p);        // write lands on accept edge: old bias -50
      expect_out(10, p + 2);
      send_exp(3, 10);
      send_exp(9, 9);
      send_exp(60, 60);
      send_exp(0, 7);
      idle(3);

      // backpressure
      write_bias(2, 0);
      output_ready = 1'b0;
      base = acc_cnt;
      send(1, 1'b0, 0, 0, p);
      send(2, 1'b0, 0, 0, p);
      input_valid = 1'b1;
      input_data  = 28'd3;
      repeat (3) begin
         check("bp_input_ready", int'(input_ready), 0);
         check("bp_hold_valid",  int'(output_valid), 1);
         check("bp_hold_data",   int'(output_data), 1);
         @(posedge clk); #1;
      end
      check("bp_accept_count", acc_cnt - base, 2);
      check("bp_hold_data_end", int'(output_data), 1);
      rel = cyc;
      expect_out(1, rel);
      expect_out(2, rel + 1);
      output_ready = 1'b1;
      send_exp(3, 3);
      send_exp(4, 4);
      send_exp(5, 5);
      send_exp(6, 6);
      idle(3);

      // reset mid-stream
      write_bias(0, 30);
      output_ready = 1'b0;
      send(11, 1'b0, 0, 0, p);
      send(12, 1'b0, 0, 0, p);
      input_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_valid", int'(output_valid), 0);
      check("midrst_data",  int'(output_data), 0);
      output_ready = 1'b1;
      tb_row = 0;
      send_exp(5, 5);
      idle(2);

      // out-of-range bias write is ignored
      write_bias(3, 100);
      send_exp(1, 1);
      send_exp(2, 2);
      idle(3);

      // SHIFT=2 instance
`ifdef MVM_POST_ROUND_EN
      sh2_case(6, 2, "sh2_pos6");
`else
      sh2_case(6, 1, "sh2_pos6");
`endif
      sh2_case(-3, 0, "sh2_neg3");

      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
         check("scoreboard_drained", exp_q.size(), 0);
      end
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
